// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one Uart8 transmitter among NUM_REQ byte producers.
// Latches the granted byte, runs the txStart/txBusy/txDone handshake and guards it with a watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [NUM_REQ*8-1:0] reqData,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [NUM_REQ-1:0]   reqDone,
    output logic [NUM_REQ-1:0]   reqErr,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           txData,
    input  logic                 txBusy,
    input  logic                 txDone,
    output logic [IDX_W-1:0]     grantIdx,
    output logic                 busy
);

    // One timer serves both the watchdog and the inter-frame gap.
    localparam int TMR_W_TO  = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMR_W_GAP = ($clog2(GAP_CYCLES) > 0) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMR_W     = (TMR_W_TO > TMR_W_GAP) ? TMR_W_TO : TMR_W_GAP;

    localparam logic [TMR_W-1:0] TMR_EXPIRE = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] GAP       = 2'd3;

    logic [1:0]         state;
    logic [TMR_W-1:0]   timer;
    logic [IDX_W-1:0]   rrPtr;

    logic               pickValid;
    logic [IDX_W-1:0]   pickIdx;
    logic [7:0]         pickData;
    logic [NUM_REQ-1:0] pickOh;
    logic [NUM_REQ-1:0] grantOh;

    // Search starts just past the last winner, so a requester that stays valid ranks last next time.
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        int cand;
        pickValid = 1'b0;
        pickIdx   = rrPtr;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rrPtr) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pickValid && cand == i && reqValid[i]) begin
                    pickValid = 1'b1;
                    pickIdx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        pickData = 8'h00;
        pickOh   = '0;
        grantOh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickIdx == IDX_W'(i)) begin
                pickData  = reqData[8*i +: 8];
                pickOh[i] = 1'b1;
            end
            if (grantIdx == IDX_W'(i)) begin
                grantOh[i] = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            rrPtr    <= IDX_W'(NUM_REQ - 1);
            txEn     <= 1'b0;
            txStart  <= 1'b0;
            txData   <= 8'h00;
            reqReady <= '0;
            reqDone  <= '0;
            reqErr   <= '0;
            grantIdx <= '0;
            busy     <= 1'b0;
        end else begin
            txEn     <= 1'b1;
            // NOTE: pulse outputs default low each cycle; branches below raise them for one cycle only.
            reqReady <= '0;
            reqDone  <= '0;
            reqErr   <= '0;

            case (state)
                IDLE: begin
                    if (pickValid) begin
                        reqReady <= pickOh;
                        txData   <= pickData;
                        grantIdx <= pickIdx;
                        rrPtr    <= pickIdx;
                        txStart  <= 1'b1;
                        busy     <= 1'b1;
                        timer    <= '0;
                        state    <= START;
                    end
                end

                START, WAIT_DONE: begin
                    // Completion beats watchdog expiry when both land on the same edge.
                    if (txDone) begin
                        reqDone <= grantOh;
                        txStart <= 1'b0;
                        timer   <= '0;
                        state   <= GAP;
                    end else if (timer == TMR_EXPIRE) begin
                        reqErr  <= grantOh;
                        txStart <= 1'b0;
                        timer   <= '0;
                        state   <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                        if (state == START && txBusy) begin
                            txStart <= 1'b0;
                            state   <= WAIT_DONE;
                        end
                    end
                end

                GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
